mc_ctrl_fsm: RTL

//  Multicycle MIPS control unit sitting directly upstream of the ALU control decoder. Decodes the

---
 rtl/mc_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: decodes IR, sequences IF/ID/EXE/MEM/WB,
// drives datapath strobes and the 3-bit alu_ctr for the ALU decoder.
module mc_ctrl_fsm #(
    parameter int unsigned TO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_ov,
    output logic [2:0]  alu_ctr,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        ir_wr,
    output logic        iord,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        ov_trap,
    output logic        illegal_op,
    output logic        mem_err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXE = 4'd2,
        S_WB  = 4'd3,
        S_MA  = 4'd4,
        S_MEM = 4'd5,
        S_LWB = 4'd6,
        S_BR  = 4'd7
    } state_e;

    localparam logic [7:0] TO_LIM = 8'(TO_CYC);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ov_q, ov_d;

    logic [5:0] opc, fn;
    logic       is_r, r_ok, is_addiu, is_ori, is_lw, is_sw, is_beq, is_j;
    logic       ovf_fn;
    logic [2:0] ctr_r;
    logic       waiting, timeout;
    logic       unused_bits;

    assign opc = instr[31:26];
    assign fn  = instr[5:0];
    assign unused_bits = ^instr[25:6];

    assign is_r     = (opc == 6'h00);
    assign is_addiu = (opc == 6'h09);
    assign is_ori   = (opc == 6'h0D);
    assign is_lw    = (opc == 6'h23);
    assign is_sw    = (opc == 6'h2B);
    assign is_beq   = (opc == 6'h04);
    assign is_j     = (opc == 6'h02);
    assign ovf_fn   = is_r && (fn == 6'h20 || fn == 6'h22);

    always_comb begin
        ctr_r = 3'b000;
        r_ok  = 1'b1;
        unique case (fn)
            6'h21:   ctr_r = 3'b000;
            6'h20:   ctr_r = 3'b001;
            6'h25:   ctr_r = 3'b010;
            6'h23:   ctr_r = 3'b100;
            6'h22:   ctr_r = 3'b101;
            6'h2B:   ctr_r = 3'b110;
            6'h2A:   ctr_r = 3'b111;
            default: r_ok  = 1'b0;
        endcase
    end

    // Wait-state counter only runs while a memory access is stalled.
    assign waiting = (state_q == S_IF || state_q == S_MEM) && !mem_ready;
    assign timeout = waiting && (cnt_q == TO_LIM);

    logic [2:0] ctr_c;
    logic       sa_c, ext_c, pcw_c, irw_c, iord_c, req_c, we_c;
    logic [1:0] sb_c, pcs_c;
    logic       rw_c, rd_c, m2r_c, ovt_c, ill_c, merr_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = (waiting && !timeout) ? cnt_q + 8'd1 : 8'd0;
        ov_d    = ov_q;
        ctr_c   = 3'b000;
        sa_c    = 1'b0;
        sb_c    = 2'b00;
        ext_c   = 1'b0;
        pcw_c   = 1'b0;
        pcs_c   = 2'b00;
        irw_c   = 1'b0;
        iord_c  = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        rw_c    = 1'b0;
        rd_c    = 1'b0;
        m2r_c   = 1'b0;
        ovt_c   = 1'b0;
        ill_c   = 1'b0;
        merr_c  = 1'b0;
        unique case (state_q)
            S_IF: begin
                req_c = 1'b1;
                sb_c  = 2'b01;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_ID;
                end else if (timeout) begin
                    merr_c = 1'b1;
                end
            end
            S_ID: begin
                sb_c  = 2'b11;
                ext_c = 1'b1;
                if ((is_r && r_ok) || is_addiu || is_ori) begin
                    state_d = S_EXE;
                end else if (is_lw || is_sw) begin
                    state_d = S_MA;
                end else if (is_beq) begin
                    state_d = S_BR;
                end else if (is_j) begin
                    pcw_c   = 1'b1;
                    pcs_c   = 2'b10;
                    state_d = S_IF;
                end else begin
                    ill_c   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                sa_c = 1'b1;
                if (is_r) begin
                    ctr_c = ctr_r;
                end else if (is_ori) begin
                    sb_c  = 2'b10;
                    ctr_c = 3'b010;
                end else begin
                    sb_c  = 2'b10;
                    ext_c = 1'b1;
                end
                ov_d    = alu_ov && ovf_fn;
                state_d = S_WB;
            end
            S_WB: begin
                rw_c    = !ov_q;
                rd_c    = is_r;
                ovt_c   = ov_q;
                ov_d    = 1'b0;
                state_d = S_IF;
            end
            S_MA: begin
                sa_c    = 1'b1;
                sb_c    = 2'b10;
                ext_c   = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
                we_c   = is_sw && !timeout;
                if (mem_ready) begin
                    state_d = is_lw ? S_LWB : S_IF;
                end else if (timeout) begin
                    merr_c  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_LWB: begin
                rw_c    = 1'b1;
                m2r_c   = 1'b1;
                state_d = S_IF;
            end
            S_BR: begin
                sa_c    = 1'b1;
                ctr_c   = 3'b100;
                pcs_c   = 2'b01;
                pcw_c   = alu_zero;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IF;
            cnt_q   <= 8'd0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    // Reset cycle must never strobe the datapath, even mid-access.
    assign alu_ctr    = rst_n ? ctr_c : 3'b000;
    assign alu_src_a  = rst_n && sa_c;
    assign alu_src_b  = rst_n ? sb_c : 2'b00;
    assign ext_op     = rst_n && ext_c;
    assign pc_wr      = rst_n && pcw_c;
    assign pc_src     = rst_n ? pcs_c : 2'b00;
    assign ir_wr      = rst_n && irw_c;
    assign iord       = rst_n && iord_c;
    assign mem_req    = rst_n && req_c;
    assign mem_we     = rst_n && we_c;
    assign reg_wr     = rst_n && rw_c;
    assign reg_dst    = rst_n && rd_c;
    assign mem_to_reg = rst_n && m2r_c;
    assign ov_trap    = rst_n && ovt_c;
    assign illegal_op = rst_n && ill_c;
    assign mem_err    = rst_n && merr_c;
    assign state      = state_q;

endmodule
